// File: rtl/plic_src_conditioner.sv
// Per-source interrupt conditioner placed in front of plic_top.
// Raw lines pass through polarity correction, a 2-flop synchronizer,
// an optional glitch filter, and level/edge shaping.
// Build option: define PLIC_SRC_FILTER_EN to enable the per-source glitch
// filter and the sticky glitch_o flags; without it stable_q follows the
// synchronizer directly (same timing as FILTER_LEN=1) and glitch_o is 0.
module plic_src_conditioner #(
  parameter int unsigned                N_SOURCE   = 30,
  parameter int unsigned                FILTER_LEN = 4,
  parameter logic [N_SOURCE-1:0]        ACTIVE_LOW = '0,
  localparam int unsigned               FCW        = $clog2(FILTER_LEN + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_SOURCE-1:0] irq_raw_i,
  input  logic [N_SOURCE-1:0] le_cfg_i,
  input  logic [N_SOURCE-1:0] glitch_clr_i,
  output logic [N_SOURCE-1:0] irq_sources_o,
  output logic [N_SOURCE-1:0] le_o,
  output logic [N_SOURCE-1:0] glitch_o
);

  logic [N_SOURCE-1:0] s1_q;
  logic [N_SOURCE-1:0] s2_q;
  logic [N_SOURCE-1:0] stable_q;
  logic [N_SOURCE-1:0] stable_d;
  logic [N_SOURCE-1:0] prev_q;

`ifdef PLIC_SRC_FILTER_EN
  logic [N_SOURCE-1:0][FCW-1:0] cnt_q;
  logic [N_SOURCE-1:0][FCW-1:0] cnt_d;
  logic [N_SOURCE-1:0]          glitch_d;

  // Filter next-state: accept a change only after FILTER_LEN stable samples
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    glitch_d = glitch_q_clr(glitch_o, glitch_clr_i);
    for (int i = 0; i < int'(N_SOURCE); i++) begin
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == FCW'(FILTER_LEN - 1)) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + FCW'(1);
        end
      end else if (cnt_q[i] != '0) begin
        // A change that reverted before acceptance; set beats a same-cycle clear
        glitch_d[i] = 1'b1;
      end
    end
  end

  function automatic logic [N_SOURCE-1:0] glitch_q_clr(input logic [N_SOURCE-1:0] flags,
                                                       input logic [N_SOURCE-1:0] clr);
    return flags & ~clr;
  endfunction

  // Filter counters and sticky glitch flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      glitch_o <= '0;
    end else begin
      cnt_q    <= cnt_d;
      glitch_o <= glitch_d;
    end
  end
`else
  logic unused_filter_cfg;

  // No filter: every synchronized sample is accepted immediately
  always_comb begin
    stable_d = s2_q;
  end

  assign glitch_o          = '0;
  assign unused_filter_cfg = ^{glitch_clr_i, 1'(FILTER_LEN), 1'(FCW)};
`endif

  // Synchronizer, accepted level, shaping and mode registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q          <= '0;
      s2_q          <= '0;
      stable_q      <= '0;
      prev_q        <= '0;
      irq_sources_o <= '0;
      le_o          <= '0;
    end else begin
      s1_q          <= irq_raw_i ^ ACTIVE_LOW;
      s2_q          <= s1_q;
      stable_q      <= stable_d;
      prev_q        <= stable_q;
      // Level: pass stable_q; edge: only the cycle right after an accepted rise
      irq_sources_o <= stable_q & ~(le_cfg_i & prev_q);
      le_o          <= le_cfg_i;
    end
  end

endmodule

// File: tb/tb_plic_src_conditioner.sv
// Scoreboard bench for plic_src_conditioner: stimulus queues expected
// output slices for specific cycles, a monitor compares them each cycle.
`timescale 1ns/1ps
module tb_plic_src_conditioner;

  localparam int unsigned N    = 30;
  localparam int unsigned FLEN = 4;
  localparam logic [N-1:0] AL  = N'(32'h0000_0002);
`ifdef PLIC_SRC_FILTER_EN
  localparam int FL   = 4;
  localparam bit FILT = 1'b1;
`else
  localparam int FL   = 1;
  localparam bit FILT = 1'b0;
`endif
  localparam int LAT = 3 + FL;

  localparam int IRQ = 0;
  localparam int LE  = 1;
  localparam int GL  = 2;

  bit           clk;
  logic         rst;
  logic [N-1:0] raw;
  logic [N-1:0] le;
  logic [N-1:0] clr;
  logic [N-1:0] irq_o;
  logic [N-1:0] le_o;
  logic [N-1:0] gl_o;

  int cyc;
  int checks;
  int failures;
  int c0;
  int c1;
  int c2;

  typedef struct {
    int           cyc;
    int           sel;
    logic [N-1:0] mask;
    logic [N-1:0] exp;
    string        name;
  } chk_t;

  chk_t sb[$];

  plic_src_conditioner #(
    .N_SOURCE   (N),
    .FILTER_LEN (FLEN),
    .ACTIVE_LOW (AL)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .irq_raw_i     (raw),
    .le_cfg_i      (le),
    .glitch_clr_i  (clr),
    .irq_sources_o (irq_o),
    .le_o          (le_o),
    .glitch_o      (gl_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] b(input int i);
    return N'(1) << i;
  endfunction

  // Insert expectation keeping the queue ordered by cycle
  task automatic expect_at(input int c, input int sel, input logic [N-1:0] mask,
                           input logic [N-1:0] exp, input string name);
    chk_t e;
    int   idx;
    e.cyc  = c;
    e.sel  = sel;
    e.mask = mask;
    e.exp  = exp;
    e.name = name;
    idx = sb.size();
    for (int k = 0; k < sb.size(); k++) begin
      if (sb[k].cyc > c) begin
        idx = k;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare every expectation due at this cycle
  initial begin
    chk_t         e;
    logic [N-1:0] act;
    forever begin
      @(negedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = (e.sel == IRQ) ? irq_o : ((e.sel == LE) ? le_o : gl_o);
        checks++;
        if (e.cyc != cyc) begin
          failures++;
          $display("FAIL %s: due at cycle %0d, seen at cycle %0d", e.name, e.cyc, cyc);
        end else if ((act & e.mask) !== (e.exp & e.mask)) begin
          failures++;
          $display("FAIL %s: cycle %0d got %h want %h (mask %h)",
                   e.name, cyc, act & e.mask, e.exp & e.mask, e.mask);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    raw = '1;
    le  = '1;
    clr = '0;

    // Reset: everything 0 while held, even with raw and le all ones
    expect_at(1, IRQ, '1, '0, "rst_irq");
    expect_at(1, LE,  '1, '0, "rst_le");
    expect_at(1, GL,  '1, '0, "rst_glitch");
    expect_at(3, IRQ, '1, '0, "rst_irq_hold");
    expect_at(3, LE,  '1, '0, "rst_le_hold");
    tick(3);

    // Release with raw high: level sources rise LAT edges later
    rst = 1'b0;
    le  = '0;
    c0  = cyc;
    expect_at(c0 + 1,       LE,  '1, '0,  "rel_le");
    expect_at(c0 + LAT - 1, IRQ, '1, '0,  "rel_irq_early");
    expect_at(c0 + LAT,     IRQ, '1, ~AL, "rel_irq_rise");
    expect_at(c0 + LAT,     GL,  '1, '0,  "rel_glitch");
    tick(LAT + 2);

    // All lines inactive
    raw = AL;
    c0  = cyc;
    expect_at(c0 + LAT - 1, IRQ, '1, ~AL, "idle_hold");
    expect_at(c0 + LAT,     IRQ, '1, '0,  "idle_fall");
    tick(LAT + 2);

    // Level source 0: rise then fall
    raw[0] = 1'b1;
    c0     = cyc;
    expect_at(c0 + LAT - 1, IRQ, b(0), '0,   "lvl_rise_early");
    expect_at(c0 + LAT,     IRQ, b(0), b(0), "lvl_rise");
    expect_at(c0 + LAT,     LE,  b(0), '0,   "lvl_le");
    tick(10);
    raw[0] = 1'b0;
    c1     = cyc;
    expect_at(c1 + LAT - 1, IRQ, b(0), b(0), "lvl_fall_early");
    expect_at(c1 + LAT,     IRQ, b(0), '0,   "lvl_fall");
    tick(LAT + 2);

    // Source 3: 2-cycle glitch, then clear the sticky flag
    raw[3] = 1'b1;
    c0     = cyc;
    expect_at(c0 + 4,       IRQ, b(3), FILT ? '0 : b(3), "glitch_irq_a");
    expect_at(c0 + 5,       IRQ, b(3), FILT ? '0 : b(3), "glitch_irq_b");
    expect_at(c0 + 6,       IRQ, b(3), '0,               "glitch_irq_c");
    expect_at(c0 + LAT + 2, IRQ, b(3), '0,               "glitch_irq_d");
    expect_at(c0 + 4,       GL,  b(3), '0,               "glitch_flag_pre");
    expect_at(c0 + 5,       GL,  b(3), FILT ? b(3) : '0, "glitch_flag_set");
    tick(2);
    raw[3] = 1'b0;
    tick(7);
    clr[3] = 1'b1;
    c2     = cyc;
    expect_at(c2,     GL, b(3), FILT ? b(3) : '0, "glitch_sticky");
    expect_at(c2 + 1, GL, b(3), '0,               "glitch_cleared");
    tick(1);
    clr[3] = 1'b0;
    tick(3);

    // Source 3 again: clear strobe on the same edge as the set; set wins
    raw[3] = 1'b1;
    c0     = cyc;
    expect_at(c0 + 4, GL, b(3), '0,               "setwin_pre");
    expect_at(c0 + 5, GL, b(3), FILT ? b(3) : '0, "setwin_set");
    tick(2);
    raw[3] = 1'b0;
    tick(2);
    clr[3] = 1'b1;
    tick(1);
    clr[3] = 1'b0;
    tick(3);
    clr[3] = 1'b1;
    c1     = cyc;
    expect_at(c1 + 1, GL, b(3), '0, "setwin_cleared");
    tick(1);
    clr[3] = 1'b0;
    tick(LAT + 2);

    // Edge source 5: one pulse per accepted rise, nothing on fall
    le[5]  = 1'b1;
    raw[5] = 1'b1;
    c0     = cyc;
    expect_at(c0 + 1,       LE,  b(5), b(5), "edge_le");
    expect_at(c0 + LAT - 1, IRQ, b(5), '0,   "edge_early");
    expect_at(c0 + LAT,     IRQ, b(5), b(5), "edge_pulse");
    expect_at(c0 + LAT + 1, IRQ, b(5), '0,   "edge_pulse_end");
    expect_at(c0 + LAT + 6, IRQ, b(5), '0,   "edge_held");
    tick(20);
    raw[5] = 1'b0;
    c1     = cyc;
    expect_at(c1 + LAT,     IRQ, b(5), '0, "edge_fall_a");
    expect_at(c1 + LAT + 1, IRQ, b(5), '0, "edge_fall_b");
    tick(10);
    raw[5] = 1'b1;
    c2     = cyc;
    expect_at(c2 + LAT - 1, IRQ, b(5), '0,   "edge2_early");
    expect_at(c2 + LAT,     IRQ, b(5), b(5), "edge2_pulse");
    expect_at(c2 + LAT + 1, IRQ, b(5), '0,   "edge2_pulse_end");
    tick(LAT + 3);
    raw[5] = 1'b0;
    tick(LAT + 2);

    // Source 1 is active-low: raw 0 asserts; then level->edge switch gives no pulse
    raw[1] = 1'b0;
    c0     = cyc;
    expect_at(c0 + LAT - 1, IRQ, b(1), '0,   "pol_early");
    expect_at(c0 + LAT,     IRQ, b(1), b(1), "pol_level");
    expect_at(c0 + LAT + 1, IRQ, b(1), b(1), "pol_level_hold");
    tick(LAT + 2);
    le[1] = 1'b1;
    c1    = cyc;
    expect_at(c1 + 1, LE,  b(1), b(1), "sw_le");
    expect_at(c1 + 1, IRQ, b(1), '0,   "sw_no_pulse_a");
    expect_at(c1 + 3, IRQ, b(1), '0,   "sw_no_pulse_b");
    tick(4);
    raw[1] = 1'b1;
    le[1]  = 1'b0;
    tick(LAT + 2);

    // Source 7: single-cycle raw pulse
    raw[7] = 1'b1;
    c0     = cyc;
    expect_at(c0 + LAT - 1, IRQ, b(7), '0,               "short_early");
    expect_at(c0 + LAT,     IRQ, b(7), FILT ? '0 : b(7), "short_pulse");
    expect_at(c0 + LAT + 1, IRQ, b(7), '0,               "short_after");
    expect_at(c0 + LAT + 2, GL,  b(7), FILT ? b(7) : '0, "short_glitch");
    tick(1);
    raw[7] = 1'b0;
    tick(LAT + 3);

    // Source 9: pulse exactly the minimum accepted width
    raw[9] = 1'b1;
    c0     = cyc;
    expect_at(c0 + LAT,        IRQ, b(9), b(9), "minw_accept");
    expect_at(c0 + 2 * FL + 2, IRQ, b(9), b(9), "minw_hold");
    expect_at(c0 + 2 * FL + 3, IRQ, b(9), '0,   "minw_fall");
    expect_at(c0 + 2 * FL + 4, GL,  b(9), '0,   "minw_no_glitch");
    tick(FL);
    raw[9] = 1'b0;
    tick(2 * FL + 6);

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 50 && sb.size() > 0; k++) tick(1);
    while (sb.size() > 0) begin
      chk_t e;
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: due at cycle %0d never checked (now %0d)", e.name, e.cyc, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
